// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer: steps the signal-generator counter increment from
// start_incr towards stop_incr once per dwell period, in single, repeat or ping-pong mode.
module sweep_ctrl #(
  parameter int WIDTH   = 9,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   start_incr,
  input  logic [WIDTH-1:0]   stop_incr,
  input  logic [WIDTH-1:0]   step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [WIDTH-1:0]   incr,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   start_q, stop_q, step_q, incr_q;
  logic [DWELL_W-1:0] reload_q, dcnt_q;
  logic               down_q, en_q, busy_q, done_q, err_q;

  // One extra bit on the step arithmetic so a step past the top of the bus never wraps.
  logic [WIDTH:0]     incr_up_d, floor_d;
  logic [DWELL_W-1:0] reload_d;
  logic               legal_d;

  assign incr_up_d = {1'b0, incr_q} + {1'b0, step_q};
  assign floor_d   = {1'b0, start_q} + {1'b0, step_q};
  assign reload_d  = (dwell == '0) ? '0 : dwell - 1'b1;
  assign legal_d   = (step != '0) && (start_incr <= stop_incr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      reload_q <= '0;
      incr_q   <= '0;
      dcnt_q   <= '0;
      down_q   <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            mode_q   <= mode;
            start_q  <= start_incr;
            stop_q   <= stop_incr;
            step_q   <= step;
            reload_q <= reload_d;
            if (legal_d) begin
              state_q <= RUN;
              incr_q  <= start_incr;
              dcnt_q  <= reload_d;
              down_q  <= 1'b0;
              en_q    <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else if (dcnt_q != '0) begin
            dcnt_q <= dcnt_q - 1'b1;
          end else begin
            dcnt_q <= reload_q;
            if (!down_q) begin
              if (incr_up_d <= {1'b0, stop_q}) begin
                incr_q <= incr_up_d[WIDTH-1:0];
              end else begin
                case (mode_q)
                  2'd1:    incr_q <= start_q;
                  2'd2:    down_q <= 1'b1;
                  default: begin
                    state_q <= IDLE;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                  end
                endcase
              end
            end else if ({1'b0, incr_q} >= floor_d) begin
              incr_q <= incr_q - step_q;
            end else begin
              down_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign incr = incr_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: stimulus queues per-cycle expected outputs,
// a monitor pops and compares them after every clock edge.
module tb_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [1:0]  mode;
  logic [8:0]  start_incr, stop_incr, step;
  logic [15:0] dwell;
  logic [8:0]  incr;
  logic        en, busy, done, err;

  sweep_ctrl #(.WIDTH(9), .DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .start_incr(start_incr), .stop_incr(stop_incr), .step(step), .dwell(dwell),
    .incr(incr), .en(en), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         id;
    logic       en, busy, done, err;
    logic [8:0] incr;
  } exp_t;

  exp_t       q[$];
  logic [8:0] seq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always begin : monitor
    exp_t x;
    @(posedge clk);
    #1;
    cyc++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      x = q.pop_front();
      checks++;
      if (x.cyc != cyc ||
          {en, busy, done, err, incr} !== {x.en, x.busy, x.done, x.err, x.incr}) begin
        errors++;
        $display("FAIL test%0d cyc=%0d got en=%b busy=%b done=%b err=%b incr=%0d required en=%b busy=%b done=%b err=%b incr=%0d",
                 x.id, x.cyc, en, busy, done, err, incr, x.en, x.busy, x.done, x.err, x.incr);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input int off, input int id, input logic e, input logic b,
                      input logic d, input logic r, input logic [8:0] v);
    exp_t x;
    x.cyc = cyc + off; x.id = id;
    x.en = e; x.busy = b; x.done = d; x.err = r; x.incr = v;
    q.push_back(x);
  endtask

  task automatic push_run(input int off0, input int id, input int hold);
    for (int i = 0; i < seq.size(); i++)
      for (int h = 0; h < hold; h++)
        push(off0 + i * hold + h, id, 1'b1, 1'b1, 1'b0, 1'b0, seq[i]);
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [8:0] si, input logic [8:0] so,
                             input logic [8:0] st, input logic [15:0] dw);
    mode = m; start_incr = si; stop_incr = so; step = st; dwell = dw;
    start = 1'b1;
    tick();
    start = 1'b0;
    // scramble config after the start edge; latched values must be used
    mode = 2'd3; start_incr = 9'd99; stop_incr = 9'd3; step = 9'd1; dwell = 16'd7;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = '0;
    start_incr = '0; stop_incr = '0; step = '0; dwell = '0;
    tick();
    push(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
    tick();
    rst = 1'b0;
    tick();

    // single ramp
    seq = '{9'd10, 9'd20, 9'd30, 9'd40};
    push_run(1, 1, 3);
    push(13, 1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd40);
    push(14, 1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd40);
    pulse_start(2'd0, 9'd10, 9'd40, 9'd10, 16'd3);
    wait_n(15);

    // repeat, stray start mid-sweep, abort on the dwell-expiry cycle
    seq = '{9'd10, 9'd20, 9'd30, 9'd40, 9'd10, 9'd20};
    push_run(1, 2, 3);
    push(19, 2, 1'b0, 1'b0, 1'b0, 1'b0, 9'd20);
    push(20, 2, 1'b0, 1'b0, 1'b0, 1'b0, 9'd20);
    pulse_start(2'd1, 9'd10, 9'd40, 9'd10, 16'd3);
    wait_n(4);
    mode = 2'd0; start_incr = 9'd100; stop_incr = 9'd200; step = 9'd5; dwell = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_n(12);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_n(2);

    // ping-pong with dwell 1, then reset mid-sweep
    seq = '{9'd10, 9'd20, 9'd30, 9'd40, 9'd40, 9'd30, 9'd20, 9'd10, 9'd10, 9'd20, 9'd30};
    push_run(1, 3, 1);
    push(12, 3, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
    pulse_start(2'd2, 9'd10, 9'd40, 9'd10, 16'd1);
    wait_n(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_n(1);

    // top of the bus: no wrap past 511
    seq = '{9'd500, 9'd508};
    push_run(1, 4, 2);
    push(5, 4, 1'b0, 1'b0, 1'b1, 1'b0, 9'd508);
    push(6, 4, 1'b0, 1'b0, 1'b0, 1'b0, 9'd508);
    pulse_start(2'd0, 9'd500, 9'd511, 9'd8, 16'd2);
    wait_n(6);

    // illegal: start above stop
    push(1, 5, 1'b0, 1'b0, 1'b1, 1'b1, 9'd508);
    push(2, 5, 1'b0, 1'b0, 1'b0, 1'b0, 9'd508);
    pulse_start(2'd0, 9'd50, 9'd40, 9'd10, 16'd3);
    wait_n(2);

    // illegal: zero step
    push(1, 6, 1'b0, 1'b0, 1'b1, 1'b1, 9'd508);
    push(2, 6, 1'b0, 1'b0, 1'b0, 1'b0, 9'd508);
    pulse_start(2'd0, 9'd10, 9'd40, 9'd0, 16'd3);
    wait_n(2);

    // dwell 0 behaves as dwell 1
    seq = '{9'd10, 9'd20, 9'd30};
    push_run(1, 7, 1);
    push(4, 7, 1'b0, 1'b0, 1'b1, 1'b0, 9'd30);
    push(5, 7, 1'b0, 1'b0, 1'b0, 1'b0, 9'd30);
    pulse_start(2'd0, 9'd10, 9'd30, 9'd10, 16'd0);
    wait_n(5);

    // start == stop: one dwell period then done
    seq = '{9'd7};
    push_run(1, 8, 2);
    push(3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 9'd7);
    pulse_start(2'd0, 9'd7, 9'd7, 9'd1, 16'd2);
    wait_n(4);

    // abort beats start in idle
    push(1, 9, 1'b0, 1'b0, 1'b0, 1'b0, 9'd7);
    push(2, 9, 1'b0, 1'b0, 1'b0, 1'b0, 9'd7);
    abort = 1'b1;
    pulse_start(2'd0, 9'd10, 9'd40, 9'd10, 16'd3);
    abort = 1'b0;
    wait_n(2);

    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
